// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet distributor:
// selection-mode constants, head/body state encoding, and destination-width helper.
package axis_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_READY = 1;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } state_t;

  // Destination index width; a single lane still carries a 1-bit tdest.
  function automatic int dest_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_packet_distributor_if.sv
// Bundled stream signals of the packet distributor.
// slave  : the distributor side (accepts the input stream, drives the lanes).
// master : the environment side (drives the input stream, sinks the lanes).
interface axis_packet_distributor_if #(
  parameter int AXIS_BYTES         = 1,
  parameter int NUM_MASTER_STREAMS = 2
);
  import axis_pkg::*;

  localparam int DEST_BITS = dest_bits(NUM_MASTER_STREAMS);

  logic                                       axis_i_tready;
  logic                                       axis_i_tvalid;
  logic                                       axis_i_tlast;
  logic [AXIS_BYTES*8-1:0]                    axis_i_tdata;
  logic [NUM_MASTER_STREAMS-1:0]              axis_o_tready;
  logic [NUM_MASTER_STREAMS-1:0]              axis_o_tvalid;
  logic [NUM_MASTER_STREAMS-1:0]              axis_o_tlast;
  logic [NUM_MASTER_STREAMS*AXIS_BYTES*8-1:0] axis_o_tdata;
  logic [DEST_BITS-1:0]                       axis_o_tdest;

  modport slave (
    input  axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_o_tready,
    output axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tdest
  );

  modport master (
    output axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_o_tready,
    input  axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tdest
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: the _p1 entry is the registered output stage,
// the _p0 entry absorbs one beat while the output is stalled so that
// in_rdy can be a pure register (not full).
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         sreset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         vld_p0;
  logic [W-1:0] data_p0;
  logic         vld_p1;
  logic [W-1:0] data_p1;
  logic         out_free;

  assign in_rdy   = !vld_p0;
  assign out_free = !vld_p1 || out_rdy;
  assign out_vld  = vld_p1;
  assign out_data = data_p1;

  // Occupancy control plus output word; the output word is cleared on reset.
  always_ff @(posedge clk) begin
    if (sreset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (out_free) begin
      if (vld_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        vld_p0  <= 1'b0;
      end else begin
        vld_p1 <= in_vld;
        if (in_vld) begin
          data_p1 <= in_data;
        end
      end
    end else if (in_vld) begin
      vld_p0 <= 1'b1;
    end
  end

  // Skid word captures the incoming beat whenever the output stage cannot take it.
  always_ff @(posedge clk) begin
    if (in_vld && !out_free) begin
      data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/axis_packet_distributor.sv
// Packet-level AXI-Stream distributor: each tlast-delimited packet is sent
// whole to one enabled lane, chosen by rotation (MODE 0) or by rotation
// skipping lanes whose tready is low (MODE 1). One registered output stage.
// Optional per-lane packet counters: define AXIS_DISTRIBUTOR_STATS_EN.
module axis_packet_distributor
  import axis_pkg::*;
#(
  parameter int AXIS_BYTES         = 1,
  parameter int NUM_MASTER_STREAMS = 2,
  parameter int MODE               = MODE_RR,
  parameter int COUNT_BITS         = 32
) (
  input  logic                                     clk,
  input  logic                                     sreset,
  input  logic [NUM_MASTER_STREAMS-1:0]            out_enable,
  axis_packet_distributor_if.slave                 axis
`ifdef AXIS_DISTRIBUTOR_STATS_EN
  ,
  output logic [NUM_MASTER_STREAMS*COUNT_BITS-1:0] pkt_count
`endif
);

  localparam int N         = NUM_MASTER_STREAMS;
  localparam int DEST_BITS = dest_bits(N);
  localparam int DATA_W    = AXIS_BYTES * 8;
  localparam int SKID_W    = DATA_W + 1 + DEST_BITS;

  state_t                state;
  logic [DEST_BITS-1:0]  last_dest;
  logic [DEST_BITS-1:0]  cur_dest;
  logic [DEST_BITS-1:0]  cand;
  logic                  cand_found;
  logic [N-1:0]          elig;
  logic [DEST_BITS-1:0]  push_dest;
  logic                  push;
  logic                  skid_rdy;
  logic                  out_vld;
  logic                  out_last;
  logic [DATA_W-1:0]     out_data;
  logic [DEST_BITS-1:0]  out_dest;
  logic [N-1:0]          lane_hit;
  logic                  sel_ready;

  if (COUNT_BITS < 1) begin : g_count_bits_invalid
  end

  assign elig = out_enable & ((MODE == MODE_READY) ? axis.axis_o_tready : {N{1'b1}});

  // Rotating search from last_dest+1; iterating k downwards lets the nearest lane win.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if ((j == (int'(last_dest) + k) % N) && elig[j]) begin
          cand_found = 1'b1;
          cand       = DEST_BITS'(j);
        end
      end
    end
  end

  assign axis.axis_i_tready = !sreset && skid_rdy && ((state == BODY) || cand_found);
  assign push               = axis.axis_i_tvalid && axis.axis_i_tready;
  assign push_dest          = (state == HEAD) ? cand : cur_dest;

  // Packet framing: lock the destination at the head, release it on the tlast beat.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state     <= HEAD;
      last_dest <= DEST_BITS'(N - 1);
      cur_dest  <= '0;
    end else if (push) begin
      if (state == HEAD) begin
        cur_dest  <= cand;
        last_dest <= cand;
        state     <= axis.axis_i_tlast ? HEAD : BODY;
      end else if (axis.axis_i_tlast) begin
        state <= HEAD;
      end
    end
  end

  // ---- stage boundary: registered output via skid buffer ----
  axis_skid_buffer #(
    .W (SKID_W)
  ) u_skid (
    .clk      (clk),
    .sreset   (sreset),
    .in_vld   (push),
    .in_rdy   (skid_rdy),
    .in_data  ({push_dest, axis.axis_i_tlast, axis.axis_i_tdata}),
    .out_vld  (out_vld),
    .out_rdy  (sel_ready),
    .out_data ({out_dest, out_last, out_data})
  );

  // Lane decode of the registered beat and the ready of the lane it targets.
  always_comb begin
    lane_hit  = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_hit[i] = (out_dest == DEST_BITS'(i));
      if (lane_hit[i]) begin
        sel_ready = axis.axis_o_tready[i];
      end
    end
  end

  assign axis.axis_o_tvalid = out_vld  ? lane_hit : '0;
  assign axis.axis_o_tlast  = out_last ? lane_hit : '0;
  assign axis.axis_o_tdata  = {N{out_data}};
  assign axis.axis_o_tdest  = out_dest;

`ifdef AXIS_DISTRIBUTOR_STATS_EN
  logic [COUNT_BITS-1:0] pkt_cnt [N];

  // Per-lane completed-packet counters, wrapping naturally.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (sreset) begin
        pkt_cnt[i] <= '0;
      end else if (axis.axis_o_tvalid[i] && axis.axis_o_tready[i] && axis.axis_o_tlast[i]) begin
        pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt_out
    assign pkt_count[g*COUNT_BITS +: COUNT_BITS] = pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_axis_packet_distributor.sv
// Directed bench for axis_packet_distributor: a 4-lane round-robin instance
// and a 3-lane ready-aware instance, with hand-computed lane sequences.
module tb_axis_packet_distributor;

  localparam int O_RDY = 0, O_VLD = 1, O_LAST = 2, O_DATA = 3, O_DEST = 4;

  logic       clk = 1'b0;
  logic       sreset;
  logic [3:0] en0;
  logic [2:0] en1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  axis_packet_distributor_if #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(4)) if0 ();
  axis_packet_distributor_if #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(3)) if1 ();

`ifdef AXIS_DISTRIBUTOR_STATS_EN
  logic [15:0] cnt0;
  logic [11:0] cnt1;
`endif

  axis_packet_distributor #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(4), .MODE(0), .COUNT_BITS(4)) dut0 (
    .clk        (clk),
    .sreset     (sreset),
    .out_enable (en0),
    .axis       (if0)
`ifdef AXIS_DISTRIBUTOR_STATS_EN
    ,
    .pkt_count  (cnt0)
`endif
  );

  axis_packet_distributor #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(3), .MODE(1), .COUNT_BITS(4)) dut1 (
    .clk        (clk),
    .sreset     (sreset),
    .out_enable (en1),
    .axis       (if1)
`ifdef AXIS_DISTRIBUTOR_STATS_EN
    ,
    .pkt_count  (cnt1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] data, input logic last);
    if (d == 0) begin
      if0.axis_i_tvalid = v; if0.axis_i_tdata = data; if0.axis_i_tlast = last;
    end else begin
      if1.axis_i_tvalid = v; if1.axis_i_tdata = data; if1.axis_i_tlast = last;
    end
  endtask

  function automatic logic [63:0] obs(input int d, input int sel);
    case (sel)
      O_RDY:  return (d == 0) ? 64'(if0.axis_i_tready) : 64'(if1.axis_i_tready);
      O_VLD:  return (d == 0) ? 64'(if0.axis_o_tvalid) : 64'(if1.axis_o_tvalid);
      O_LAST: return (d == 0) ? 64'(if0.axis_o_tlast)  : 64'(if1.axis_o_tlast);
      O_DATA: return (d == 0) ? 64'(if0.axis_o_tdata)  : 64'(if1.axis_o_tdata);
      O_DEST: return (d == 0) ? 64'(if0.axis_o_tdest)  : 64'(if1.axis_o_tdest);
      default: return '0;
    endcase
  endfunction

  // Expected broadcast data word: the byte replicated on every lane.
  function automatic logic [63:0] bcast(input int d, input logic [7:0] b);
    logic [63:0] r = '0;
    for (int i = 0; i < ((d == 0) ? 4 : 3); i++) r |= 64'(b) << (8 * i);
    return r;
  endfunction

  // Streams nsend beats of an nb-beat packet with tvalid held high; every beat
  // must be accepted immediately and appear on 'lane' one cycle later.
  task automatic send_pkt(input int d, input int nb, input int nsend, input int lane,
                          input logic [7:0] base, input logic [3:0] mask_mid);
    for (int b = 0; b < nsend; b++) begin
      drive(d, 1'b1, base + 8'(b), b == nb - 1);
      #1;
      check($sformatf("d%0d rdy %0h", d, base + 8'(b)), obs(d, O_RDY), 64'd1);
      @(negedge clk);
      if (b == 0 && d == 0) en0 = mask_mid;
      check($sformatf("d%0d vld %0h", d, base + 8'(b)), obs(d, O_VLD), 64'(1) << lane);
      check($sformatf("d%0d data %0h", d, base + 8'(b)), obs(d, O_DATA), bcast(d, base + 8'(b)));
      check($sformatf("d%0d last %0h", d, base + 8'(b)), obs(d, O_LAST),
            (b == nb - 1) ? (64'(1) << lane) : 64'd0);
      check($sformatf("d%0d dest %0h", d, base + 8'(b)), obs(d, O_DEST), 64'(lane));
    end
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int lanes_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int lanes_m  [4] = '{1, 3, 1, 3};
    int in_idx, out_idx;
    logic in_acc, out_acc;

    // Reset state
    sreset = 1'b1;
    en0 = 4'hF; en1 = 3'h7;
    if0.axis_o_tready = 4'hF; if1.axis_o_tready = 3'h7;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("rst vld", obs(0, O_VLD), 64'd0);
    check("rst last", obs(0, O_LAST), 64'd0);
    check("rst data", obs(0, O_DATA), 64'd0);
    check("rst dest", obs(0, O_DEST), 64'd0);
    check("rst rdy", obs(0, O_RDY), 64'd0);
    check("rst vld1", obs(1, O_VLD), 64'd0);
    sreset = 1'b0;
    #1;
    check("post-rst rdy", obs(0, O_RDY), 64'd1);

    // Strict rotation over all lanes, back-to-back 3-beat packets
    for (int p = 0; p < 8; p++) send_pkt(0, 3, 3, lanes_rr[p], 8'(8'h10 + 4 * p), 4'hF);

    // Enable mask 1010: lanes 1,3,1,3
    en0 = 4'b1010;
    for (int p = 0; p < 4; p++) send_pkt(0, 3, 3, lanes_m[p], 8'(8'h40 + 4 * p), 4'b1010);

    // Mask cleared mid-packet: packet completes on lane 1, next head stalls
    send_pkt(0, 3, 3, 1, 8'h50, 4'b0000);
    drive(0, 1'b1, 8'h60, 1'b0);
    #1;
    check("stall rdy", obs(0, O_RDY), 64'd0);
    @(negedge clk);
    check("stall vld", obs(0, O_VLD), 64'd0);
    check("stall rdy2", obs(0, O_RDY), 64'd0);
    en0 = 4'b0100;
    send_pkt(0, 2, 2, 2, 8'h60, 4'b0100);
    idle(0);

    // Lane 3 tready toggling during the packet
    en0 = 4'hF;
    in_idx = 0; out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      if (in_idx < 4) drive(0, 1'b1, 8'(8'h70 + in_idx), in_idx == 3);
      else            drive(0, 1'b0, 8'h00, 1'b0);
      if0.axis_o_tready = (cyc % 2 == 0) ? 4'hF : 4'h7;
      #1;
      in_acc  = if0.axis_i_tvalid && if0.axis_i_tready;
      out_acc = if0.axis_o_tvalid[3] && if0.axis_o_tready[3];
      check($sformatf("tog others c%0d", cyc), obs(0, O_VLD) & 64'h7, 64'd0);
      if (out_acc) begin
        check($sformatf("tog data %0d", out_idx), obs(0, O_DATA), bcast(0, 8'(8'h70 + out_idx)));
        check($sformatf("tog last %0d", out_idx), obs(0, O_LAST), (out_idx == 3) ? 64'h8 : 64'h0);
        out_idx++;
      end
      @(negedge clk);
      if (in_acc) in_idx++;
    end
    check("tog beats out", 64'(out_idx), 64'd4);
    if0.axis_o_tready = 4'hF;
    idle(0);

    // Reset on beat 2 of a 4-beat packet; next packet restarts at lane 0
    send_pkt(0, 1, 1, 0, 8'h80, 4'hF);
    send_pkt(0, 4, 2, 1, 8'h90, 4'hF);
    drive(0, 1'b1, 8'h92, 1'b0);
    sreset = 1'b1;
    @(negedge clk);
    check("midrst vld", obs(0, O_VLD), 64'd0);
    check("midrst last", obs(0, O_LAST), 64'd0);
    check("midrst data", obs(0, O_DATA), 64'd0);
    check("midrst dest", obs(0, O_DEST), 64'd0);
    sreset = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    #1;
    check("midrst rdy", obs(0, O_RDY), 64'd1);
    send_pkt(0, 2, 2, 0, 8'hA0, 4'hF);
    idle(0);

`ifdef AXIS_DISTRIBUTOR_STATS_EN
    check("cnt after rst", 64'(cnt0), 64'h0001);
    en0 = 4'b0001;
    for (int p = 0; p < 16; p++) send_pkt(0, 1, 1, 0, 8'(8'hB0 + p), 4'b0001);
    idle(0);
    check("cnt wrap", 64'(cnt0), 64'h0001);
`endif

    // Ready-aware selection on the 3-lane instance
    send_pkt(1, 2, 2, 0, 8'hC0, 4'h0);
    if1.axis_o_tready = 3'b101;
    send_pkt(1, 2, 2, 2, 8'hD0, 4'h0);
    if1.axis_o_tready = 3'b111;
    send_pkt(1, 1, 1, 0, 8'hE0, 4'h0);
    idle(1);
    if1.axis_o_tready = 3'b000;
    drive(1, 1'b1, 8'hF0, 1'b1);
    #1;
    check("m1 none ready rdy", obs(1, O_RDY), 64'd0);
    if1.axis_o_tready = 3'b010;
    #1;
    check("m1 lane1 ready rdy", obs(1, O_RDY), 64'd1);
    @(negedge clk);
    check("m1 lane1 vld", obs(1, O_VLD), 64'h2);
    check("m1 lane1 dest", obs(1, O_DEST), 64'd1);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
